// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Carries into bit positions 0..3 of one 4-bit lookahead group.
  function automatic logic [3:0] cla_carries(logic [3:0] g, logic [3:0] p, logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Carry-lookahead subtractor a + ~b + 1 from 4-bit groups; carry_o high means a >= b.
module cla_subtractor
  import div_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             carry_o
);

  localparam int unsigned NumGrp = (Width + 3) / 4;
  localparam int unsigned PadW   = NumGrp * 4;

  logic [PadW-1:0] a_pad, nb_pad, p, g, carry_vec;
  logic [NumGrp:0] gc;

  // Pad bits become a=0, ~b=1: pure propagate, so the top group carry equals bit Width's.
  assign a_pad  = PadW'(a_i);
  assign nb_pad = ~PadW'(b_i);
  assign p      = a_pad ^ nb_pad;
  assign g      = a_pad & nb_pad;
  assign gc[0]  = 1'b1;

  for (genvar k = 0; k < NumGrp; k++) begin : g_grp
    logic grp_g, grp_p;
    assign carry_vec[4*k +: 4] = cla_carries(g[4*k +: 4], p[4*k +: 4], gc[k]);
    assign grp_p = &p[4*k +: 4];
    assign grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                   ((&p[4*k+1 +: 3]) & g[4*k]);
    assign gc[k+1] = grp_g | (grp_p & gc[k]);
  end

  if (PadW > Width) begin : g_pad
    logic [PadW-Width-1:0] unused_pad;
    assign unused_pad = carry_vec[PadW-1:Width] ^ p[PadW-1:Width];
  end

  assign diff_o  = p[Width-1:0] ^ carry_vec[Width-1:0];
  assign carry_o = gc[NumGrp];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional early exit on zero divisor with div_zero flag: define SEQ_DIVIDER_ZERO_CHECK_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;  // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step;
  logic             no_borrow;
  logic             unused_diff_msb;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  cla_subtractor #(
    .Width(WIDTH + 1)
  ) u_sub (
    .a_i    (shifted),
    .b_i    ({1'b0, dvs_q}),
    .diff_o (diff),
    .carry_o(no_borrow)
  );

  // A kept difference is below the divisor, so its MSB is always zero.
  assign rem_step        = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic dz_q, dz_d;
  logic zero_div;
  assign zero_div = (dvs_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
        if (zero_div) begin
          state_d = StDone;
          quo_d   = '1;
          rmd_d   = dvd_q;
          dz_d    = 1'b1;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
          quo_d   = {dvd_q[WIDTH-2:0], no_borrow};
          rmd_d   = rem_step;
          dz_d    = 1'b0;
        end
`else
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quo_d   = {dvd_q[WIDTH-2:0], no_borrow};
          rmd_d   = rem_step;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider, WIDTH=8; inputs driven and outputs sampled on negedge.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_zero;

  int n_cmp = 0;
  int n_err = 0;
  int seen_done;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge (cycle 1).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done counting cycles since acceptance; optionally re-pulses start 9/3 in RUN.
  task automatic run_check(input string tag, input int inject_at, input int exp_cyc,
                           input int exp_busy, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz);
    int cyc, nbusy;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (cyc == inject_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy_cycles"}, nbusy, exp_busy);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_zero"}, div_zero, edz);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'd200, 8'd7);
    chk("a_busy_first", busy, 1);
    run_check("a", 0, 9, 8, 8'd28, 8'd4, 1'b0);
    @(negedge clk);
    chk("a_done_pulse", done, 0);
    chk("a_hold_quotient", quotient, 28);
    chk("a_hold_remainder", remainder, 4);

    start_op(8'd255, 8'd1);
    run_check("b", 0, 9, 8, 8'd255, 8'd0, 1'b0);
    @(negedge clk);
    start_op(8'd5, 8'd9);
    run_check("c", 0, 9, 8, 8'd0, 8'd5, 1'b0);
    @(negedge clk);
    start_op(8'd255, 8'd16);
    run_check("d", 0, 9, 8, 8'd15, 8'd15, 1'b0);
    @(negedge clk);

    start_op(8'd100, 8'd0);
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    run_check("zero", 0, 2, 1, 8'hFF, 8'd100, 1'b1);
`else
    run_check("zero", 0, 9, 8, 8'hFF, 8'd100, 1'b0);
`endif
    @(negedge clk);

    start_op(8'd200, 8'd7);
    run_check("ignore", 3, 9, 8, 8'd28, 8'd4, 1'b0);
    @(negedge clk);

    start_op(8'd50, 8'd6);
    run_check("bb1", 0, 9, 8, 8'd8, 8'd2, 1'b0);
    start_op(8'd81, 8'd9);
    chk("bb_done_drop", done, 0);
    chk("bb_busy_no_idle", busy, 1);
    chk("bb_hold_quotient", quotient, 8);
    chk("bb_hold_remainder", remainder, 2);
    run_check("bb2", 0, 9, 8, 8'd9, 8'd0, 1'b0);
    @(negedge clk);

    start_op(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    chk("rr_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_quotient", quotient, 0);
    chk("rr_remainder", remainder, 0);
    chk("rr_div_zero", div_zero, 0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("rr_no_done", seen_done, 0);
    rst_n = 1'b1;
    start_op(8'd199, 8'd13);
    chk("rr_first_edge_busy", busy, 1);
    run_check("rr", 0, 9, 8, 8'd15, 8'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits, legal values a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start  input  1  request a division, sampled only in IDLE or DONE.
REQ-005 The block SHALL have port dividend  input  WIDTH  unsigned numerator, captured with start.
REQ-006 The block SHALL have port divisor  input  WIDTH  unsigned denominator, captured with start.
REQ-007 The block SHALL have port busy  output  1  high while state is RUN.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-009 The block SHALL have port quotient  output  WIDTH  result, held until next accepted start.
REQ-010 The block SHALL have port remainder  output  WIDTH  result, held until next accepted start.
REQ-011 The block SHALL have port div_zero  output  1  divisor-was-zero flag, held with results.

Function
REQ-012 The block SHALL implement states IDLE, RUN, DONE: IDLE -start-> RUN; RUN -count==WIDTH-1-> DONE; DONE -start-> RUN, else -> IDLE.
REQ-013 The block SHALL accept start on any edge where the state is IDLE or DONE, latching dividend and divisor, clearing the partial remainder and the iteration counter.
REQ-014 The block SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 The block SHALL perform restoring division, one quotient bit per RUN cycle, MSB first: shift remainder left by 1 bringing in the next dividend bit, subtract divisor over WIDTH+1 bits, keep the difference and set the quotient bit to 1 if non-negative, else restore and set the bit to 0.
REQ-016 The block SHALL assert done for exactly one cycle, WIDTH+1 cycles after the cycle in which start was accepted; busy SHALL be high for exactly WIDTH cycles.
REQ-017 The block SHALL update quotient, remainder and div_zero only on the edge entering DONE; the values SHALL hold through IDLE until the next DONE.
REQ-018 On back-to-back operation (start accepted in DONE), done SHALL drop on the next cycle and the previous results SHALL remain visible until the new DONE.
REQ-019 All arithmetic SHALL be unsigned; the result SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor for divisor != 0.

Reset
REQ-020 When rst_n is low, the block SHALL force state to IDLE and set busy, done, div_zero to 0 and quotient, remainder, counter and operand registers to 0, independent of clk.
REQ-021 When reset asserts mid-RUN, the block SHALL abandon the operation with no done pulse; after release, it SHALL accept start on the first edge.

Configuration
REQ-022 With macro SEQ_DIVIDER_ZERO_CHECK_EN defined, the block SHALL check a zero divisor at start, go RUN->DONE after one cycle (done 2 cycles after start), and return quotient all-ones, remainder = dividend, div_zero=1.
REQ-023 Without SEQ_DIVIDER_ZERO_CHECK_EN, the block SHALL tie div_zero to 0 and let a zero divisor run the full WIDTH iterations, which naturally yields quotient all-ones and remainder = dividend.

Structure
REQ-024 A shared package div_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default width constant.
REQ-025 The block SHALL instantiate one sub-module, cla_subtractor, a (WIDTH+1)-bit carry-lookahead subtractor (a + ~b + 1) built from 4-bit lookahead groups with group carry ripple, whose borrow-out gives the quotient bit.

Verification
REQ-026 The bench SHALL cover WIDTH=8: start with 200/7 -> done at cycle 9 after start, quotient=28, remainder=4, div_zero=0.
REQ-027 The bench SHALL cover 255/1 -> quotient=255, remainder=0; and 5/9 -> quotient=0, remainder=5.
REQ-028 The bench SHALL cover 100/0 with the macro defined -> done at cycle 2, quotient=0xFF, remainder=100, div_zero=1; without the macro -> done at cycle 9, same quotient and remainder, div_zero=0.
REQ-029 The bench SHALL cover start re-pulsed with 9/3 during RUN of 200/7 -> ignored, result 28/4.
REQ-030 The bench SHALL cover back-to-back 50/6 then start in DONE with 81/9 -> first result 8/2, second 9/0, with no IDLE cycle between.
REQ-031 The bench SHALL cover rst_n low at RUN cycle 4 -> all outputs 0 at once, no done; a new start after release completes correctly.
